// File: rtl/div_16x8_seq.sv
`default_nettype none
// ============================================================================
// div_16x8_seq : 16/8 unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_TRUNC_EN: 12-step approximate divide of A[15:4].
// Revision: 1.0
// ============================================================================
module div_16x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dz,
  output logic        out_valid,
  input  logic        out_ready
);

`ifdef DIV_TRUNC_EN
  localparam int ITER = 12;
`else
  localparam int ITER = 16;
`endif

  localparam logic [4:0] c_ITER_CNT = 5'(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [15:0] r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_rem;
  logic [15:0] r_q;
  logic [4:0]  r_cnt;
  logic        r_dz;

  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_diff;
  logic [15:0] w_q_step;
  logic        w_last;
  logic        w_accept;

  // Shifted partial remainder is 9 bits wide; the difference always fits 8.
  assign w_shift  = {r_rem, r_a[15]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  assign w_diff   = w_shift[7:0] - r_b;
  assign w_q_step = {r_q[14:0], w_ge};
  assign w_last   = (r_cnt == 5'd1);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = (B == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= 16'd0;
      r_b   <= 8'd0;
      r_rem <= 8'd0;
      r_q   <= 16'd0;
      r_cnt <= 5'd0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a <= A;
            r_b <= B;
            if (B == 8'd0) begin
              r_q   <= 16'hFFFF;
              r_rem <= A[7:0];
              r_dz  <= 1'b1;
              r_cnt <= 5'd0;
            end else begin
              r_q   <= 16'd0;
              r_rem <= 8'd0;
              r_dz  <= 1'b0;
              r_cnt <= c_ITER_CNT;
            end
          end
        end
        S_RUN: begin
          r_a   <= {r_a[14:0], 1'b0};
          r_rem <= w_ge ? w_diff : w_shift[7:0];
          r_cnt <= r_cnt - 5'd1;
`ifdef DIV_TRUNC_EN
          // Only 12 quotient bits are produced; align them to A's weighting.
          r_q   <= w_last ? {w_q_step[11:0], 4'b0000} : w_q_step;
`else
          r_q   <= w_q_step;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign Q  = r_q;
  assign R  = r_rem;
  assign dz = r_dz;

endmodule
`default_nettype wire

// File: doc/div_16x8_seq.md
DIV_16X8_SEQ -- requirements
Module: div_16x8_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port A, input, 16 bits: unsigned dividend.
REQ-004 The block SHALL have the port B, input, 8 bits: unsigned divisor.
REQ-005 The block SHALL have the port in_valid, input, 1 bit: A/B are valid.
REQ-006 The block SHALL have the port in_ready, output, 1 bit: block accepts an operand pair.
REQ-007 The block SHALL have the port Q, output, 16 bits: quotient.
REQ-008 The block SHALL have the port R, output, 8 bits: remainder.
REQ-009 The block SHALL have the port dz, output, 1 bit: divide-by-zero flag for the current result.
REQ-010 The block SHALL have the port out_valid, output, 1 bit: Q/R/dz are valid.
REQ-011 The block SHALL have the port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 An accept SHALL occur when in_valid=1 and in_ready=1 on a clock edge; A and B SHALL be registered at that edge, and later input changes SHALL be ignored.
REQ-015 On accept with B!=0, the block SHALL move IDLE->RUN, clear the partial remainder, and load the iteration counter with ITER (16).
REQ-016 Each RUN cycle SHALL perform one restoring step:
- shift the 9-bit partial remainder left, bringing in the next dividend bit MSB-first;
- if the result is >= B, subtract B and shift a quotient bit of 1 in; otherwise shift in 0;
- decrement the counter.
REQ-017 After the step in which the counter reaches 0, the FSM SHALL move RUN->DONE; out_valid SHALL rise exactly ITER+1 cycles after the accept edge.
REQ-018 On accept with B=0, the block SHALL move IDLE->DONE directly (out_valid one cycle after accept) with Q=16'hFFFF, R=A[7:0] and dz=1.
REQ-019 For B!=0, dz SHALL be 0, Q SHALL be floor(A/B) and R SHALL be A mod B, with R < B always.
REQ-020 In DONE, Q, R and dz SHALL hold stable until out_valid=1 and out_ready=1 on a clock edge, at which point the FSM SHALL move DONE->IDLE.
REQ-021 in_ready SHALL NOT be asserted in the cycle of the DONE->IDLE transition, so the minimum spacing between accepts is ITER+2 cycles.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 in_valid SHALL be ignored outside IDLE.

Reset
REQ-024 While rst_n=0, all of the following SHALL hold asynchronously:
- FSM = IDLE;
- Q = 0, R = 0, dz = 0;
- out_valid = 0, in_ready = 1;
- counter and partial remainder = 0.
REQ-025 Assertion of rst_n during RUN or DONE SHALL abort the operation with no output, and the block SHALL accept new operands on the first edge after release.

Configuration
REQ-026 The macro DIV_TRUNC_EN SHALL select truncated, approximate division.
REQ-027 With DIV_TRUNC_EN defined:
- ITER SHALL be 12, processing A[15:4] only;
- Q SHALL equal floor(A[15:4]/B) << 4, with Q[3:0]=0;
- R SHALL equal A[15:4] mod B;
- out_valid SHALL rise 13 cycles after accept;
- divide-by-zero behaviour SHALL be unchanged.
REQ-028 With DIV_TRUNC_EN undefined, the block SHALL be exact per REQ-019 with ITER=16.

Verification
REQ-029 The bench SHALL cover each of the following directed scenarios:
- A=1000, B=7, out_ready=1 -> out_valid at accept+17; Q=142, R=6, dz=0.
- A=16'hFFFF, B=1 -> Q=16'hFFFF, R=0; A=5, B=200 -> Q=0, R=5.
- A=16'h1234, B=0 -> out_valid at accept+1; Q=16'hFFFF, R=8'h34, dz=1.
- A=1000, B=7 with out_ready held 0 for 5 cycles after out_valid -> Q/R stable throughout; in_ready=0 until the cycle after the handshake; a second pair offered early is not accepted.
- rst_n pulsed low at accept+8 -> out_valid never rises; in_ready=1 immediately; next pair A=100, B=9 -> Q=11, R=1.
- With DIV_TRUNC_EN: A=1000, B=7 -> out_valid at accept+13; Q=128, R=6.
